// File: rtl/multi_duck_gen_if.sv
// Pixel/game bus for multi_duck_gen.
// The master side drives the pixel stream, frame tick and gun inputs.
// The slave side returns the pixel colour, the hit score and the flash indicator.
interface multi_duck_gen_if;
  logic       frame_tick;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       trigger;
  logic       detect;
  logic [5:0] bg_rgb;
  logic [5:0] RGB;
  logic [7:0] hit_count;
  logic       flash_active;

  modport master (
    output frame_tick, col, row, valid, trigger, detect, bg_rgb,
    input  RGB, hit_count, flash_active
  );

  modport slave (
    input  frame_tick, col, row, valid, trigger, detect, bg_rgb,
    output RGB, hit_count, flash_active
  );
endinterface

// File: rtl/multi_duck_gen.sv
// multi_duck_gen: several bouncing targets for a light-gun game.
//
// - A flash sequence blanks the screen, then lights one target per frame so
//   the photodiode can tell which target the gun points at.
// - A hit target falls to the floor, rests for LANDED_DELAY frames, then
//   respawns at its home slot.
// - All game state advances only on frame_tick.
// - The pixel colour is registered with one cycle of latency.
//
// Optional feature: define SPEED_RAMP_EN to speed a target up by one
// pixel/frame on each axis every time it respawns, capped at SPD_MAX.
module multi_duck_gen #(
  parameter int NUM_DUCKS    = 2,
  parameter int BOX_W        = 50,
  parameter int BOX_H        = 50,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int HS_INIT      = 5,
  parameter int VS_INIT      = 2,
  parameter int SPD_MAX      = 15,
  parameter int FALL_SPD     = 5,
  parameter int LANDED_DELAY = 60
) (
  input  logic            clk,
  input  logic            rst,
  multi_duck_gen_if.slave bus
);

  // Per-target state codes.
  localparam logic [1:0] D_FLYING = 2'd0;
  localparam logic [1:0] D_HIT    = 2'd1;
  localparam logic [1:0] D_LANDED = 2'd2;

  // Flash sequence states. The white states occupy F_WHITE0..F_WLAST, one per target.
  localparam logic [2:0] F_IDLE   = 3'd0;
  localparam logic [2:0] F_BLACK  = 3'd1;
  localparam logic [2:0] F_WHITE0 = 3'd2;
  localparam logic [2:0] F_WLAST  = 3'(NUM_DUCKS + 1);
  localparam logic [2:0] F_HELD   = 3'(NUM_DUCKS + 2);

  localparam logic [10:0] MAX_L   = 11'(SCREEN_W - BOX_W);
  localparam logic [10:0] MAX_T   = 11'(SCREEN_H - BOX_H);
  localparam logic [10:0] BOX_W11 = 11'(BOX_W);
  localparam logic [10:0] BOX_H11 = 11'(BOX_H);
  localparam logic [10:0] FALL11  = 11'(FALL_SPD);
  localparam logic [7:0]  DELAY8  = 8'(LANDED_DELAY);

  // Starting speeds never exceed the speed cap.
  localparam int         HS_START = (HS_INIT > SPD_MAX) ? SPD_MAX : HS_INIT;
  localparam int         VS_START = (VS_INIT > SPD_MAX) ? SPD_MAX : VS_INIT;
  localparam logic [5:0] HS0      = 6'(HS_START);
  localparam logic [5:0] VS0      = 6'(VS_START);
`ifdef SPEED_RAMP_EN
  localparam logic [5:0] SPD_CAP  = 6'(SPD_MAX);
`endif

  logic [2:0] flash_q, flash_d;
  logic [7:0] hit_q, hit_d;
  logic [5:0] rgb_q, rgb_d;
  logic [5:0] colour;
  logic       in_white;
  logic [1:0] white_idx;
  logic       hit_en;

  // Per-target views, gathered from the generate blocks.
  logic [1:0]           duck_st_w [NUM_DUCKS];
  logic [9:0]           box_l_w   [NUM_DUCKS];
  logic [9:0]           box_t_w   [NUM_DUCKS];
  logic [5:0]           hs_w      [NUM_DUCKS];
  logic [5:0]           vs_w      [NUM_DUCKS];
  logic [NUM_DUCKS-1:0] inside_w;
  logic [NUM_DUCKS-1:0] hit_w;
  logic [NUM_DUCKS-1:0] white_pix_w;

  assign in_white  = (flash_q >= F_WHITE0) && (flash_q <= F_WLAST);
  assign white_idx = 2'(flash_q - F_WHITE0);
  assign hit_en    = bus.frame_tick && in_white && bus.detect;

  // One-axis bounce.
  // - Moving up-range: clamp at lim and turn around when the next step would reach it.
  // - Moving down-range: clamp at 0 and turn around when the next step would pass it.
  function automatic void bounce(input  logic [9:0]  pos,
                                 input  logic [5:0]  spd,
                                 input  logic        dir,
                                 input  logic [10:0] lim,
                                 output logic [9:0]  pos_n,
                                 output logic        dir_n);
    pos_n = pos;
    dir_n = dir;
    if (dir) begin
      if (({1'b0, pos} + {5'd0, spd}) >= lim) begin
        pos_n = lim[9:0];
        dir_n = 1'b0;
      end else begin
        pos_n = pos + {4'd0, spd};
      end
    end else begin
      if (pos < {4'd0, spd}) begin
        pos_n = 10'd0;
        dir_n = 1'b1;
      end else begin
        pos_n = pos - {4'd0, spd};
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DUCKS; gi++) begin : g_duck
      localparam logic [9:0] HOME_L = 10'(gi * 2 * BOX_W);
      localparam logic       FWD0   = ((gi % 2) == 0);

      logic [1:0]  st_q, st_d;
      logic [9:0]  l_q, l_d, t_q, t_d;
      logic        fwd_q, fwd_d, dn_q, dn_d;
      logic [5:0]  hs_q, hs_d, vs_q, vs_d;
      logic [7:0]  tmr_q, tmr_d;
      logic [10:0] l_end, t_end, fall_sum;
      logic [7:0]  tmr_inc;

      // Containment uses 11-bit right/bottom edges so boxes near the screen edge never wrap.
      assign l_end = {1'b0, l_q} + BOX_W11;
      assign t_end = {1'b0, t_q} + BOX_H11;
      assign inside_w[gi] = ({1'b0, bus.col} >= {1'b0, l_q}) && ({1'b0, bus.col} < l_end) &&
                            ({1'b0, bus.row} >= {1'b0, t_q}) && ({1'b0, bus.row} < t_end);

      // A target can only be shot while it is flying and it is its own white frame.
      assign hit_w[gi]       = hit_en && (white_idx == 2'(gi)) && (st_q == D_FLYING);
      assign white_pix_w[gi] = in_white && (white_idx == 2'(gi)) && inside_w[gi] &&
                               (st_q == D_FLYING);

      assign duck_st_w[gi] = st_q;
      assign box_l_w[gi]   = l_q;
      assign box_t_w[gi]   = t_q;
      assign hs_w[gi]      = hs_q;
      assign vs_w[gi]      = vs_q;

      // Per-frame motion: bounce while flying, fall when hit, rest then respawn when landed.
      always_comb begin
        st_d     = st_q;
        l_d      = l_q;
        t_d      = t_q;
        fwd_d    = fwd_q;
        dn_d     = dn_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        tmr_d    = tmr_q;
        fall_sum = {1'b0, t_q} + FALL11;
        tmr_inc  = tmr_q + 8'd1;
        if (bus.frame_tick) begin
          case (st_q)
            D_FLYING: begin
              if (hit_w[gi]) begin
                // The shot freezes the target where it was hit.
                st_d = D_HIT;
              end else begin
                bounce(l_q, hs_q, fwd_q, MAX_L, l_d, fwd_d);
                bounce(t_q, vs_q, dn_q, MAX_T, t_d, dn_d);
              end
            end
            D_HIT: begin
              if (fall_sum >= MAX_T) begin
                t_d   = MAX_T[9:0];
                st_d  = D_LANDED;
                tmr_d = 8'd0;
              end else begin
                t_d = fall_sum[9:0];
              end
            end
            D_LANDED: begin
              if (tmr_inc == DELAY8) begin
                st_d  = D_FLYING;
                l_d   = HOME_L;
                t_d   = 10'd0;
                fwd_d = FWD0;
                dn_d  = 1'b1;
                tmr_d = 8'd0;
`ifdef SPEED_RAMP_EN
                if (hs_q < SPD_CAP) hs_d = hs_q + 6'd1;
                if (vs_q < SPD_CAP) vs_d = vs_q + 6'd1;
`endif
              end else begin
                tmr_d = tmr_inc;
              end
            end
            default: st_d = D_FLYING;
          endcase
        end
      end

      // Target state register; reset puts the target back in its home slot at starting speed.
      always_ff @(posedge clk) begin
        if (rst) begin
          st_q  <= D_FLYING;
          l_q   <= HOME_L;
          t_q   <= 10'd0;
          fwd_q <= FWD0;
          dn_q  <= 1'b1;
          hs_q  <= HS0;
          vs_q  <= VS0;
          tmr_q <= 8'd0;
        end else begin
          st_q  <= st_d;
          l_q   <= l_d;
          t_q   <= t_d;
          fwd_q <= fwd_d;
          dn_q  <= dn_d;
          hs_q  <= hs_d;
          vs_q  <= vs_d;
          tmr_q <= tmr_d;
        end
      end
    end
  endgenerate

  // Flash sequence: black frame, one white frame per target, then wait for trigger release.
  always_comb begin
    flash_d = flash_q;
    if (bus.frame_tick) begin
      case (flash_q)
        F_IDLE:  if (bus.trigger) flash_d = F_BLACK;
        F_BLACK: flash_d = F_WHITE0;
        F_HELD:  if (!bus.trigger) flash_d = F_IDLE;
        default: begin
          if (in_white) flash_d = (flash_q == F_WLAST) ? F_HELD : flash_q + 3'd1;
          else          flash_d = F_IDLE;
        end
      endcase
    end
  end

  // Pixel colour: flash frames override the normal scene; otherwise the lowest-index target wins.
  always_comb begin
    colour = bus.bg_rgb;
    for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
      if (inside_w[i]) colour = (duck_st_w[i] == D_HIT) ? 6'b111100 : 6'b110000;
    end
    if (flash_q == F_BLACK) begin
      colour = 6'd0;
    end else if (in_white) begin
      colour = (|white_pix_w) ? 6'b111111 : 6'd0;
    end
  end

  assign rgb_d = bus.valid ? colour : 6'd0;
  assign hit_d = ((|hit_w) && (hit_q != 8'hFF)) ? hit_q + 8'd1 : hit_q;

  // Flash state, saturating score and registered pixel output.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q <= F_IDLE;
      hit_q   <= 8'd0;
      rgb_q   <= 6'd0;
    end else begin
      flash_q <= flash_d;
      hit_q   <= hit_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.RGB          = rgb_q;
  assign bus.hit_count    = hit_q;
  assign bus.flash_active = (flash_q == F_BLACK) || in_white;

endmodule

// File: doc/multi_duck_gen.md
MULTI_DUCK_GEN -- requirements
Module: multi_duck_gen

Interface
REQ-001 SHALL have parameter NUM_DUCKS, default 2, number of independent targets (1..4).
REQ-002 SHALL have parameters BOX_W 50, BOX_H 50: target size in pixels.
REQ-003 SHALL have parameters SCREEN_W 640, SCREEN_H 480: visible area; NUM_DUCKS*2*BOX_W <= SCREEN_W.
REQ-004 SHALL have parameters HS_INIT 5, VS_INIT 2, SPD_MAX 15, FALL_SPD 5, LANDED_DELAY 60: speeds and the landed hold time in frames.
REQ-005 SHALL have port clk  in  1  pixel clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse per frame; all game state advances only on it.
REQ-008 SHALL have ports col, row  in  10 each  current pixel coordinates.
REQ-009 SHALL have port valid  in  1  pixel is in the visible area.
REQ-010 SHALL have ports trigger, detect  in  1 each  gun trigger and photodiode hit.
REQ-011 SHALL have port bg_rgb  in  6  background colour for the current pixel.
REQ-012 SHALL have port RGB  out  6  registered pixel colour.
REQ-013 SHALL have port hit_count  out  8  total hits, saturating.
REQ-014 SHALL have port flash_active  out  1  high while the flash FSM is in BLACK or WHITE_k.

Function
REQ-015 Flash FSM SHALL have states IDLE, BLACK, WHITE_0..WHITE_{NUM_DUCKS-1}, HELD, advancing only on frame_tick.
- IDLE&trigger->BLACK; BLACK->WHITE_0; WHITE_k->WHITE_{k+1}; last WHITE->HELD; HELD&!trigger->IDLE; otherwise hold.
REQ-016 Each duck i SHALL have a state FLYING, HIT or LANDED, plus box_l, box_t (10b), forward, down, hs, vs (6b) and an 8b landed timer.
REQ-017 FLYING, on frame_tick:
- Horizontal: if forward and box_l+hs >= SCREEN_W-BOX_W, clamp box_l to SCREEN_W-BOX_W and clear forward. If !forward and box_l < hs, set box_l to 0 and set forward. Else move box_l by ±hs.
- Vertical: the same rule, using box_t, vs, SCREEN_H-BOX_H and down.
REQ-018 Hit rule: if frame_tick, the FSM is in WHITE_k, detect=1 and duck k is FLYING, duck k SHALL go to HIT and hit_count SHALL increment (saturating at 255).
- That tick's position update for duck k is suppressed.
REQ-019 HIT, per frame_tick:
- box_t += FALL_SPD, clamped to SCREEN_H-BOX_H.
- box_l is held.
- The duck goes to LANDED on the tick when box_t reaches SCREEN_H-BOX_H.
REQ-020 LANDED timer:
- Clear on entry; increment per frame_tick.
- When it reaches LANDED_DELAY, respawn: box_l=i*2*BOX_W, box_t=0, forward=(i even), down=1; state goes to FLYING.
REQ-021 Pixel colour, by flash state:
- BLACK: 0.
- WHITE_k: 6'b111111 if the pixel is inside duck k's box and duck k is FLYING, else 0.
- Otherwise: the lowest-index duck whose box contains the pixel gives 6'b110000 (FLYING/LANDED) or 6'b111100 (HIT); no duck gives bg_rgb.
REQ-022 Box containment SHALL be box_l<=col<box_l+BOX_W and box_t<=row<box_t+BOX_H, using 11-bit sums with no wrap.
REQ-023 RGB SHALL be registered with 1-cycle latency: RGB(t+1) = valid(t) ? colour(t) : 0.
REQ-024 Detect and trigger outside frame_tick SHALL be ignored.

Reset
REQ-025 On rst, the next clock SHALL set:
- flash FSM to IDLE;
- every duck to FLYING, at its respawn position, with hs=HS_INIT, vs=VS_INIT and timer 0;
- hit_count=0, RGB=0, flash_active=0.
- Reset mid-flash or mid-fall SHALL abort the sequence with no hit counted.
REQ-026 rst SHALL override a coincident frame_tick.

Configuration
REQ-027 Macro SPEED_RAMP_EN controls speed on respawn:
- Defined: each respawn increments that duck's hs and vs by 1, saturating at SPD_MAX.
- Undefined: hs and vs stay at HS_INIT and VS_INIT permanently.

Verification
REQ-028 Reset, then 10 frame_ticks, NUM_DUCKS=2 -> duck0 box_l=50, box_t=20; duck1 box_l=100 moving reverse, i.e. 100-50=50; hit_count=0.
REQ-029 trigger held across ticks with detect=1 only during WHITE_1 -> FSM path IDLE,BLACK,WHITE_0,WHITE_1,HELD; duck1 HIT, duck0 FLYING, hit_count=1; release trigger -> IDLE next tick.
REQ-030 Duck0 HIT at box_t=400 -> after 6 ticks box_t=430 and LANDED; after 60 further ticks respawn at (0,0); with SPEED_RAMP_EN hs=6, vs=3; without, hs=5, vs=2.
REQ-031 Duck at box_l=588 forward, hs=5 -> next tick box_l=590, forward=0; at box_l=3 reverse -> box_l=0, forward=1.
REQ-032 col=60,row=10 inside duck0's box, valid=1, IDLE -> RGB=6'b110000 one cycle later; valid=0 -> RGB=0; pixel in no box -> RGB=bg_rgb.
REQ-033 Assert rst during WHITE_0 with detect=1 -> IDLE, hit_count=0, all ducks FLYING at respawn positions.
